logic_op_issuer: RTL and testbench
==================================

# logic_op_issuer

Initiator-side controller for the 4-bit logic unit. Accepts logic-operation commands over a valid/ready handshake and drives the unit's select and operand inputs. Samples the unit's 4-bit result after a programmable settle time and returns it over a second valid/ready handshake. Checks every result against an internal expected value and keeps a saturating mismatch count, giving datapath and board tests a self-checking front end for the logic unit.

## Interface
Parameters:
- SETTLE_CYCLES, default 1: cycles operands and select are held before the result is sampled; legal range 1..15.
- ERR_W, default 8: width of the mismatch counter.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: issuer can accept a command; high only in IDLE.
- cmd_op, input, 2: operation code; 00 NOT a, 01 OR, 10 AND, 11 XOR.
- cmd_a, input, 4: operand a.
- cmd_b, input, 4: operand b (ignored for NOT).
- s0, output, 1: logic-unit select bit 0 (cmd_op[0]).
- s1, output, 1: logic-unit select bit 1 (cmd_op[1]).
- a, output, 4: operand a to the logic unit.
- b, output, 4: operand b to the logic unit.
- opl, input, 4: result from the logic unit.
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_data, output, 4: sampled opl.
- rsp_op, output, 2: echo of the command's op.
- rsp_mismatch, output, 1: rsp_data differs from the expected result.
- err_clr, input, 1: synchronous clear of err_cnt.
- err_cnt, output, ERR_W: saturating mismatch count.

## Operation
- FSM states are IDLE, DRIVE and RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register op, a and b, load settle counter with SETTLE_CYCLES, and go to DRIVE.
- DRIVE:
  - s1/s0/a/b are driven from the command registers.
  - The counter decrements each cycle.
  - In the cycle the counter is 1, sample opl into rsp_data.
  - Compute expected = f(op,a,b): ~a, a|b, a&b, a^b.
  - Set rsp_mismatch = (opl != expected) and go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data, rsp_op and rsp_mismatch are held stable until rsp_valid&&rsp_ready, then return to IDLE.
- s1/s0/a/b keep their last values in IDLE and RESP. They change only on command acceptance.
- err_cnt:
  - Increments by 1 on entry to RESP when the mismatch is 1.
  - Saturates at 2^ERR_W-1.
  - err_clr forces it to 0.
  - If err_clr coincides with a counting mismatch, the result is 1.
- A command is never accepted in the same cycle a response is consumed. Back-to-back throughput is one command per SETTLE_CYCLES+2 cycles.

## Timing
- Reset values:
  - State IDLE, so cmd_ready=1 during reset.
  - rsp_valid=0, rsp_data=0, rsp_op=0, rsp_mismatch=0.
  - s0=s1=0, a=b=0, err_cnt=0, settle counter 0.
- Latency: accept in cycle T gives rsp_valid high from cycle T+1+SETTLE_CYCLES.
- opl is sampled at the end of cycle T+SETTLE_CYCLES. The logic unit is purely combinational, so SETTLE_CYCLES=1 is sufficient in-chip.
- rsp_valid, once high, stays high until the handshake completes.
- If rsp_ready is already high on the first RESP cycle, the response completes in one cycle.
- A reset assertion mid-command (DRIVE or RESP) immediately aborts the command. The response is discarded and all outputs go to their reset values.
- cmd_valid while not in IDLE is ignored. The command is not stored, and the producer must hold it.

## Structure
- Package logic_op_pkg contains:
  - opcode constants OP_NOT=2'b00, OP_OR=2'b01, OP_AND=2'b10, OP_XOR=2'b11;
  - the FSM state encoding (IDLE, DRIVE, RESP);
  - the 4-bit result width constant.
- One sub-module, logic_expect: combinational op/a/b to expected 4-bit result, shared with the testbench's scoreboard.
- The issuer connects to the logic unit at the top level; it does not instantiate the unit.

## Test plan
- Reset release, then cmd op=11 a=4'b1010 b=4'b0110 with a correct unit → rsp_data=4'b1100, rsp_op=11, rsp_mismatch=0, rsp_valid at accept+2 (SETTLE_CYCLES=1).
- All four ops with a=4'b1100, b=4'b1010 → NOT 0011, OR 1110, AND 1000, XOR 0110, err_cnt stays 0.
- Bench forces opl=4'b0000 for an AND of 1111,1111 → rsp_mismatch=1, err_cnt=1. Asserting err_clr in the same cycle as a further mismatch → err_cnt=1. Forcing mismatches with ERR_W=2 → err_cnt saturates at 3.
- Hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_data and a/b/s0/s1 stay stable, cmd_ready stays 0, and a cmd_valid pulse is not accepted. Raising rsp_ready → IDLE on the next cycle.
- SETTLE_CYCLES=4 → opl is sampled at accept+4 and rsp_valid rises at accept+5. Changing opl at accept+3 is not reflected; the value present at accept+4 is.
- Assert rst_n=0 during DRIVE → rsp_valid never rises, all outputs return to their reset values, and after release cmd_ready=1 and the next command completes normally.

Source files
------------

// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-unit issuer: opcodes, FSM encoding, result width.
package logic_op_pkg;

  localparam int RES_W = 4;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/logic_expect.sv
// Reference model of the logic unit: the result a correct unit must produce for op/a/b.
module logic_expect
  import logic_op_pkg::*;
(
  input  logic [1:0]       op,
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_NOT:  y = ~a;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      default: y = a ^ b;
    endcase
  end

endmodule

// File: rtl/logic_op_issuer.sv
// Drives the logic unit from a command stream, samples its result after a settle
// time, returns it as a response and counts results that disagree with the model.
module logic_op_issuer
  import logic_op_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // sender holds its payload stable while valid is high and ready is low.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RES_W-1:0] cmd_a,
  input  logic [RES_W-1:0] cmd_b,
  output logic             s0,
  output logic             s1,
  output logic [RES_W-1:0] a,
  output logic [RES_W-1:0] b,
  input  logic [RES_W-1:0] opl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic [1:0]       rsp_op,
  output logic             rsp_mismatch,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state;
  logic [3:0]       cnt;
  logic [1:0]       op_q;
  logic [RES_W-1:0] exp_res;
  logic             sample;
  logic             miss;

  logic_expect u_expect (
    .op (op_q),
    .a  (a),
    .b  (b),
    .y  (exp_res)
  );

  assign s0        = op_q[0];
  assign s1        = op_q[1];
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  // The last settle cycle is the one where opl is captured and checked.
  assign sample = (state == DRIVE) && (cnt <= 4'd1);
  assign miss   = sample && (opl != exp_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      op_q         <= 2'b00;
      a            <= '0;
      b            <= '0;
      rsp_data     <= '0;
      rsp_op       <= 2'b00;
      rsp_mismatch <= 1'b0;
      err_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            a     <= cmd_a;
            b     <= cmd_b;
            cnt   <= SETTLE_LD;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          cnt <= cnt - 4'd1;
          if (sample) begin
            rsp_data     <= opl;
            rsp_op       <= op_q;
            rsp_mismatch <= (opl != exp_res);
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A clear that lands on a counting mismatch keeps that one mismatch.
      if (err_clr) begin
        err_cnt <= miss ? ERR_W'(1) : '0;
      end else if (miss && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_logic_op_issuer.sv
// Bench for logic_op_issuer: three instances (settle 1/err 8, settle 1/err 2,
// settle 4/err 8) share one command stream; responses are checked from a queue.
module tb_logic_op_issuer;
  import logic_op_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_a = 4'h0, cmd_b = 4'h0;
  logic       rsp_ready = 1'b0;
  logic       err_clr = 1'b0;

  logic       cr0, s00, s10, rv0, rm0;
  logic [3:0] a0, b0, rd0;
  logic [1:0] ro0, st0;
  logic [7:0] ec0;
  logic       cr1, s01, s11, rv1, rm1;
  logic [3:0] a1, b1, rd1;
  logic [1:0] ro1, st1;
  logic [1:0] ec1;
  logic       cr2, s02, s12, rv2, rm2;
  logic [3:0] a2, b2, rd2;
  logic [1:0] ro2, st2;
  logic [7:0] ec2;

  logic [3:0] unit0, unit2, opl0, opl2;
  logic       f0_en = 1'b0, f2_en = 1'b0;
  logic [3:0] f0_val = 4'h0, f2_val = 4'h0;

  // Logic-unit stand-ins, each overridable by the bench to inject faults.
  logic_expect unit_m0 (.op({s10, s00}), .a(a0), .b(b0), .y(unit0));
  logic_expect unit_m2 (.op({s12, s02}), .a(a2), .b(b2), .y(unit2));
  assign opl0 = f0_en ? f0_val : unit0;
  assign opl2 = f2_en ? f2_val : unit2;

  logic_op_issuer #(.SETTLE_CYCLES(1), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cr0), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .s0(s00), .s1(s10), .a(a0), .b(b0), .opl(opl0),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_data(rd0), .rsp_op(ro0),
    .rsp_mismatch(rm0), .err_clr(err_clr), .err_cnt(ec0), .dbg_state(st0)
  );

  logic_op_issuer #(.SETTLE_CYCLES(1), .ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cr1), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .s0(s01), .s1(s11), .a(a1), .b(b1), .opl(opl0),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .rsp_op(ro1),
    .rsp_mismatch(rm1), .err_clr(err_clr), .err_cnt(ec1), .dbg_state(st1)
  );

  logic_op_issuer #(.SETTLE_CYCLES(4), .ERR_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cr2), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .s0(s02), .s1(s12), .a(a2), .b(b2), .opl(opl2),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_data(rd2), .rsp_op(ro2),
    .rsp_mismatch(rm2), .err_clr(err_clr), .err_cnt(ec2), .dbg_state(st2)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] e0 = 8'd0;
  logic [1:0] e1 = 2'd0;
  // Entry: {op, data expected from u0/u1, mismatch of u0/u1, data expected from u2}
  logic [10:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_f(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
    case (op)
      2'b00:   return ~x;
      2'b01:   return x | y;
      2'b10:   return x & y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, ".u0"}, {cr0, rv0, rd0, ro0, rm0, s10, s00, a0, b0, ec0, st0}, {1'b1, 28'd0});
    chk({tag, ".u1"}, {cr1, rv1, rd1, ro1, rm1, s11, s01, a1, b1, ec1, st1}, {1'b1, 22'd0});
    chk({tag, ".u2"}, {cr2, rv2, rd2, ro2, rm2, s12, s02, a2, b2, ec2, st2}, {1'b1, 28'd0});
  endtask

  // good: correct result; force_m/fval: unit fault on u0/u1; clr: err_clr during
  // the sampling cycle; hold: cycles of rsp_ready=0 in RESP; tmo: opl glitches on u2.
  task automatic issue(input string tag, input logic [1:0] op, input logic [3:0] av,
                       input logic [3:0] bv, input logic [3:0] good, input logic force_m,
                       input logic [3:0] fval, input logic clr, input int hold, input logic tmo);
    logic [3:0]  d0;
    logic        m0;
    logic [10:0] e;
    int          cyc, lat0, lat2;
    d0 = force_m ? fval : good;
    m0 = force_m && (fval != good);
    @(negedge clk);
    chk({tag, ".idle_ready"}, {cr0, cr2}, 2'b11);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = av; cmd_b = bv;
    f0_en = force_m; f0_val = fval;
    exp_q.push_back({op, d0, m0, good});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    err_clr = clr;
    if (m0) begin
      if (clr) begin e0 = 8'd1; e1 = 2'd1; end
      else begin
        if (e0 != 8'hFF) e0 = e0 + 8'd1;
        if (e1 != 2'h3) e1 = e1 + 2'd1;
      end
    end else if (clr) begin
      e0 = 8'd0; e1 = 2'd0;
    end
    cyc = 0; lat0 = 0; lat2 = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc >= 2) err_clr = 1'b0;
      if (tmo) begin
        f2_en = (cyc == 3) || (cyc >= 5);
        f2_val = ~good;
      end
      if (rv0 && lat0 == 0) lat0 = cyc;
      if (rv2 && lat2 == 0) lat2 = cyc;
    end while (!(rv0 && rv2) && cyc < 40);
    f2_en = 1'b0;
    chk({tag, ".lat_s1"}, lat0, 2);
    chk({tag, ".lat_s4"}, lat2, 5);
    e = exp_q.pop_front();
    chk({tag, ".rsp_u0"}, {ro0, rd0, rm0}, e[10:4]);
    chk({tag, ".rsp_u1"}, {rv1, ro1, rd1, rm1}, {1'b1, e[10:4]});
    chk({tag, ".rsp_u2"}, {ro2, rd2, rm2}, {e[10:9], e[3:0], 1'b0});
    chk({tag, ".err"}, {ec0, ec1, ec2}, {e0, e1, 8'd0});
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_op = ~op; cmd_a = ~av; cmd_b = ~bv;
      end
      if (i == 3) cmd_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".hold"}, {rv0, cr0, rd0, a0, b0, s10, s00, rv2, cr2},
          {1'b1, 1'b0, d0, av, bv, op, 1'b1, 1'b0});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    f0_en = 1'b0;
    @(negedge clk);
    chk({tag, ".done"}, {rv0, cr0, rv2, cr2, a0, b0, s10, s00}, {4'b0101, av, bv, op});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rop;
    logic [3:0] ra, rb;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;

    issue("xor", 2'b11, 4'b1010, 4'b0110, 4'b1100, 1'b0, 4'h0, 1'b0, 0, 1'b0);
    issue("not", 2'b00, 4'b1100, 4'b1010, 4'b0011, 1'b0, 4'h0, 1'b0, 0, 1'b0);
    issue("or",  2'b01, 4'b1100, 4'b1010, 4'b1110, 1'b0, 4'h0, 1'b0, 0, 1'b0);
    issue("and", 2'b10, 4'b1100, 4'b1010, 4'b1000, 1'b0, 4'h0, 1'b0, 0, 1'b0);
    issue("xor2", 2'b11, 4'b1100, 4'b1010, 4'b0110, 1'b0, 4'h0, 1'b0, 0, 1'b0);

    issue("miss1", 2'b10, 4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
    issue("miss_clr", 2'b10, 4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      issue("miss_sat", 2'b01, 4'b0101, 4'b0010, 4'b0111, 1'b1, 4'b1000, 1'b0, 0, 1'b0);

    issue("stall", 2'b01, 4'b0011, 4'b0100, 4'b0111, 1'b0, 4'h0, 1'b0, 5, 1'b0);
    issue("settle", 2'b11, 4'b0101, 4'b0011, 4'b0110, 1'b0, 4'h0, 1'b0, 0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      issue("rand", rop, ra, rb, ref_f(rop, ra, rb), 1'b0, 4'h0, 1'b0, $urandom_range(0, 2), 1'b0);
    end

    // Abort a command mid-DRIVE with reset.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 4'b1001; cmd_b = 4'b0110;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    e0 = 8'd0; e1 = 2'd0;
    chk_rst("abort");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort.quiet", {rv0, rv1, rv2, cr0, cr2}, 5'b00011);
    end
    rst_n = 1'b1;
    issue("post_rst", 2'b10, 4'b1110, 4'b0111, 4'b0110, 1'b0, 4'h0, 1'b0, 0, 1'b0);

    issue("miss2", 2'b00, 4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b1110, 1'b0, 0, 1'b0);
    issue("clr_only", 2'b11, 4'b1111, 4'b0000, 4'b1111, 1'b0, 4'h0, 1'b1, 0, 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
